// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the two-port data-memory arbiter:
//   - port-id constants (PORT_CPU / PORT_DBG)
//   - stage-1 pipeline entry struct (valid, port, wr, addr, wdata)
//   - addr_err(): alignment / range check of a byte address
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int unsigned ARB_ADDR_W = 32;
    localparam int unsigned ARB_DATA_W = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef struct packed {
        logic                  valid;
        logic                  port;
        logic                  wr;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } stage1_t;

    // A word access is legal only when word aligned and the whole word
    // lies inside memory, i.e. addr <= last_word (= MEM_DEPTH - 4).
    function automatic logic addr_err(input logic [ARB_ADDR_W-1:0] addr,
                                      input logic [ARB_ADDR_W-1:0] last_word);
        return (addr[1:0] != 2'b00) || (addr > last_word);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter with combinational grant.
//   clk, rst   : clock / asynchronous active-high reset
//   req0, req1 : requests
//   gnt0, gnt1 : grants (combinational, at most one high)
// On contention the port that was not granted most recently wins. The
// last-winner register resets to PORT_DBG so port 0 wins the first conflict,
// and it only moves when a grant is actually given.
// -----------------------------------------------------------------------------
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic r_last;

    assign gnt0 = req0 && (!req1 || (r_last == PORT_DBG));
    assign gnt1 = req1 && (!req0 || (r_last == PORT_CPU));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= PORT_DBG;
        end else if (gnt0) begin
            r_last <= PORT_CPU;
        end else if (gnt1) begin
            r_last <= PORT_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one byte-addressed, big-endian 32-bit data memory between the CPU
// data port (port 0) and the debug/DMA port (port 1). Two-stage pipeline:
// cycle N arbitrate/accept, N+1 memory access, N+2 response (rvalid pulse).
//
// Ports:
//   clk, rst                         clock / async active-high reset
//   reqX, addrX, wrX, wdataX         request side of port X (X = 0, 1)
//   gntX                             combinational accept
//   rvalidX, rdataX, errX            registered response of port X
//   mem_addr, mem_wdata, mem_wr      memory command (from stage 1)
//   mem_rdata                        combinational memory read of mem_addr
//   perf_gnt0/1, perf_conflict       saturating counters (DMEM_ARB_PERF_EN)
//
// Optional feature macro: DMEM_ARB_PERF_EN adds the performance counters.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ARB_ADDR_W,
    parameter int unsigned DATA_W    = ARB_DATA_W,
    parameter int unsigned MEM_DEPTH = 1024
`ifdef DMEM_ARB_PERF_EN
    ,
    parameter int unsigned PERF_W    = 16
`endif
)(
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              wr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,

    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              wr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_gnt0,
    output logic [PERF_W-1:0] perf_gnt1,
    output logic [PERF_W-1:0] perf_conflict
`endif
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_DEPTH - 4);

    logic              w_gnt0;
    logic              w_gnt1;
    stage1_t           w_s1_next;
    stage1_t           r_s1;
    logic              w_s1_err;
    logic [DATA_W-1:0] w_resp_data;

    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_err0;
    logic              r_err1;

    // ---------------- stage 0: arbitration ----------------
    rr_arbiter2 u_rr (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .gnt0 (w_gnt0),
        .gnt1 (w_gnt1)
    );

    assign gnt0 = w_gnt0;
    assign gnt1 = w_gnt1;

    // NOTE: the whole struct gets a default first so every field is assigned
    // on every path and no latch is inferred.
    always_comb begin
        w_s1_next       = '0;
        w_s1_next.valid = w_gnt0 | w_gnt1;
        w_s1_next.port  = w_gnt1 ? PORT_DBG : PORT_CPU;
        w_s1_next.wr    = w_gnt1 ? wr1    : wr0;
        w_s1_next.addr  = w_gnt1 ? addr1  : addr0;
        w_s1_next.wdata = w_gnt1 ? wdata1 : wdata0;
    end

    // The payload is only reloaded on a grant, so mem_addr/mem_wdata keep
    // their last values while the arbiter is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
        end else if (w_s1_next.valid) begin
            r_s1 <= w_s1_next;
        end else begin
            r_s1.valid <= 1'b0;
        end
    end

    // ---------------- stage 1: memory access ----------------
    assign w_s1_err    = addr_err(r_s1.addr, LAST_WORD);
    assign mem_addr    = r_s1.addr;
    assign mem_wdata   = r_s1.wdata;
    assign mem_wr      = r_s1.valid & r_s1.wr & ~w_s1_err;
    assign w_resp_data = (r_s1.wr || w_s1_err) ? '0 : mem_rdata;

    // ---------------- stage 2: per-port response ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
        end else begin
            r_rvalid0 <= r_s1.valid && (r_s1.port == PORT_CPU);
            r_rvalid1 <= r_s1.valid && (r_s1.port == PORT_DBG);
            if (r_s1.valid && (r_s1.port == PORT_CPU)) begin
                r_rdata0 <= w_resp_data;
                r_err0   <= w_s1_err;
            end
            if (r_s1.valid && (r_s1.port == PORT_DBG)) begin
                r_rdata1 <= w_resp_data;
                r_err1   <= w_s1_err;
            end
        end
    end

    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;
    assign err0    = r_err0;
    assign err1    = r_err1;

`ifdef DMEM_ARB_PERF_EN
    // ---------------- saturating performance counters ----------------
    logic [PERF_W-1:0] r_perf_gnt0;
    logic [PERF_W-1:0] r_perf_gnt1;
    logic [PERF_W-1:0] r_perf_conflict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_gnt0     <= '0;
            r_perf_gnt1     <= '0;
            r_perf_conflict <= '0;
        end else begin
            if (w_gnt0 && (r_perf_gnt0 != '1)) begin
                r_perf_gnt0 <= r_perf_gnt0 + PERF_W'(1);
            end
            if (w_gnt1 && (r_perf_gnt1 != '1)) begin
                r_perf_gnt1 <= r_perf_gnt1 + PERF_W'(1);
            end
            if (req0 && req1 && (r_perf_conflict != '1)) begin
                r_perf_conflict <= r_perf_conflict + PERF_W'(1);
            end
        end
    end

    assign perf_gnt0     = r_perf_gnt0;
    assign perf_gnt1     = r_perf_gnt1;
    assign perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. A simple SRAM model sits on the
// memory side; a transaction-level reference (grant rule, a queue of
// accepted requests with their grant cycle, and a word array) predicts
// grants, memory strobes and responses. Optional counters are checked when
// DMEM_ARB_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, wr0, gnt0, rvalid0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, wr1, gnt1, rvalid1, err1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perf_gnt0, perf_gnt1, perf_conflict;
`endif

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .addr0     (addr0),
        .wr0       (wr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .rdata0    (rdata0),
        .err0      (err0),
        .req1      (req1),
        .addr1     (addr1),
        .wr1       (wr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata1    (rdata1),
        .err1      (err1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_gnt0     (perf_gnt0),
        .perf_gnt1     (perf_gnt1),
        .perf_conflict (perf_conflict)
`endif
    );

    // ---------------- SRAM on the memory side ----------------
    logic [31:0] sram [256];
    assign mem_rdata = (mem_addr < 32'd1024) ? sram[mem_addr[9:2]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (mem_wr && (mem_addr < 32'd1024)) sram[mem_addr[9:2]] <= mem_wdata;
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          g;       // cycle in which the request was granted
        bit          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] data;
    } txn_t;

    txn_t        q[$];
    logic [31:0] ref_mem [256];
    int          cyc;
    bit          last_win;
    bit          exp_g0, exp_g1;
    bit          obs_g0, obs_g1;
    logic [31:0] exp_maddr, exp_mwdata, hold0, hold1;
    int          errors = 0;
    int          checks = 0;

    function automatic bit is_err(input logic [31:0] a);
        return ((a % 4) != 0) || (a > 32'd1020);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic p0(input bit r, input logic [31:0] a, input bit w, input logic [31:0] d);
        req0 = r; addr0 = a; wr0 = w; wdata0 = d;
    endtask

    task automatic p1(input bit r, input logic [31:0] a, input bit w, input logic [31:0] d);
        req1 = r; addr1 = a; wr1 = w; wdata1 = d;
    endtask

    // One clock cycle: called #1 after a rising edge with inputs already set.
    task automatic cycle();
        bit   ev0, ev1, emw;
        txn_t t0, t1, n;
        @(negedge clk);
        if (req0 && req1) begin
            exp_g0 = last_win;       // port 0 wins when port 1 was granted last
            exp_g1 = !last_win;
        end else begin
            exp_g0 = req0;
            exp_g1 = req1;
        end
        obs_g0 = gnt0;
        obs_g1 = gnt1;
        check("gnt0", gnt0, exp_g0);
        check("gnt1", gnt1, exp_g1);
        ev0 = 0; ev1 = 0; emw = 0;
        foreach (q[i]) begin
            if (q[i].g == cyc - 1 && q[i].wr && !q[i].err) emw = 1;
            if (q[i].g == cyc - 2) begin
                if (q[i].port) begin ev1 = 1; t1 = q[i]; end
                else           begin ev0 = 1; t0 = q[i]; end
            end
        end
        check("mem_wr", mem_wr, emw);
        check("mem_addr", mem_addr, exp_maddr);
        check("mem_wdata", mem_wdata, exp_mwdata);
        check("rvalid0", rvalid0, ev0);
        check("rvalid1", rvalid1, ev1);
        if (ev0) begin
            check("rdata0", rdata0, t0.data);
            check("err0", err0, t0.err);
            hold0 = t0.data;
        end else begin
            check("rdata0_hold", rdata0, hold0);
        end
        if (ev1) begin
            check("rdata1", rdata1, t1.data);
            check("err1", err1, t1.err);
            hold1 = t1.data;
        end else begin
            check("rdata1_hold", rdata1, hold1);
        end
        @(posedge clk);
        if (exp_g0 || exp_g1) begin
            n.g     = cyc;
            n.port  = exp_g1;
            n.wr    = exp_g1 ? wr1 : wr0;
            n.addr  = exp_g1 ? addr1 : addr0;
            n.wdata = exp_g1 ? wdata1 : wdata0;
            n.err   = is_err(n.addr);
            n.data  = 32'h0;
            q.push_back(n);
            last_win   = exp_g1;
            exp_maddr  = n.addr;
            exp_mwdata = n.wdata;
        end
        // The access of the request granted one cycle ago completes at this edge.
        foreach (q[i]) begin
            if (q[i].g == cyc - 1 && !q[i].err) begin
                if (q[i].wr) ref_mem[q[i].addr / 4] = q[i].wdata;
                else         q[i].data = ref_mem[q[i].addr / 4];
            end
        end
        while (q.size() > 0 && q[0].g <= cyc - 2) q.delete(0);
        cyc++;
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned s;
        s = $urandom_range(0, 9);
        if (s == 0) return 32'h3FC;
        if (s == 1) return 32'h400 + $urandom_range(0, 3) * 4;
        if (s == 2) return $urandom_range(0, 63) * 4 + $urandom_range(1, 3);
        return $urandom_range(0, 15) * 4;
    endfunction

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] conf_before;
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        rst = 1'b1;
        p0(0, 0, 0, 0);
        p1(0, 0, 0, 0);
        q.delete();
        cyc = 0; last_win = 1'b1;
        exp_maddr = 0; exp_mwdata = 0; hold0 = 0; hold1 = 0;

        // ---- reset state ----
        @(posedge clk); #1;
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rvalid1", rvalid1, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_err1", err1, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // ---- single write then read, port 0 ----
        p0(1, 32'h10, 1, 32'hDEADBEEF); cycle();
        p0(0, 0, 0, 0);                 cycle();
        p0(1, 32'h10, 0, 0);            cycle();
        p0(0, 0, 0, 0);                 cycle(); cycle();
        check("t1_rdata0", rdata0, 32'hDEADBEEF);

        // ---- contention for 6 cycles: grants alternate starting at port 0 ----
        p1(1, 32'h04, 0, 0); cycle();
        p0(1, 32'h08, 0, 0);
        p1(1, 32'h0C, 0, 0);
`ifdef DMEM_ARB_PERF_EN
        conf_before = perf_conflict;
`endif
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("alternate_gnt0", obs_g0, (i % 2) == 0);
        end
`ifdef DMEM_ARB_PERF_EN
        check("perf_conflict", perf_conflict - conf_before, 6);
`endif
        p0(0, 0, 0, 0); p1(0, 0, 0, 0);
        cycle(); cycle();

        // ---- back-to-back on port 1 ----
        for (int i = 0; i < 4; i++) begin
            p1(1, i * 4, 1, $urandom); cycle();
        end
        for (int i = 0; i < 4; i++) begin
            p1(1, i * 4, 0, 0); cycle();
        end
        p1(1, 32'h20, 1, 32'h0BAD_F00D); cycle();
        p1(1, 32'h20, 0, 0);             cycle();
        p1(0, 0, 0, 0); cycle(); cycle();
        check("b2b_write_then_read", rdata1, 32'h0BAD_F00D);

        // ---- misaligned and out of range ----
        p0(1, 32'h13, 1, 32'h1234_5678); cycle();
        p0(1, 32'h13, 0, 0);             cycle();
        p0(0, 0, 0, 0);
        p1(1, 32'h3FC, 1, 32'hA5A5_0001); cycle();
        p1(1, 32'h3FC, 0, 0);             cycle();
        p1(1, 32'h400, 1, 32'hFFFF_FFFF); cycle();
        p1(1, 32'h400, 0, 0);             cycle();
        p1(0, 0, 0, 0); cycle(); cycle();
        check("oor_err1", err1, 1);
        check("oor_rdata1", rdata1, 0);

        // ---- reset mid-flight ----
        p1(1, 32'h04, 0, 0);              cycle();
        p1(0, 0, 0, 0);
        p0(1, 32'h30, 1, 32'hCAFE_F00D); cycle();
        p0(0, 0, 0, 0);
        check("pre_rst_mem_wr", mem_wr, 1);
        check("pre_rst_rvalid1", rvalid1, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_mem_wr", mem_wr, 0);
        check("mid_rst_rvalid1", rvalid1, 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        q.delete();
        last_win = 1'b1;
        exp_maddr = 0; exp_mwdata = 0; hold0 = 0; hold1 = 0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        cyc += 2;
        check("rst_word_unchanged", sram[12], ref_mem[12]);

        // ---- first contention after reset goes to port 0; port 1 holds ----
        p0(1, 32'h30, 0, 0);
        p1(1, 32'h44, 1, 32'h5A5A_1234); cycle();
        check("post_rst_first_gnt0", obs_g0, 1);
        p0(0, 0, 0, 0);                  cycle();
        check("hold_gnt1", obs_g1, 1);
        p1(0, 0, 0, 0);
        check("hold_mem_addr", mem_addr, 32'h44);
        check("hold_mem_wdata", mem_wdata, 32'h5A5A_1234);
        p0(1, 32'h44, 0, 0); cycle();
        p0(0, 0, 0, 0);      cycle(); cycle();

        // ---- randomized traffic; a losing port keeps its request ----
        for (int k = 0; k < 400; k++) begin
            if (!(req0 && !exp_g0)) p0($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 1) == 1, $urandom);
            if (!(req1 && !exp_g1)) p1($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 1) == 1, $urandom);
            cycle();
        end
        p0(0, 0, 0, 0); p1(0, 0, 0, 0);
        cycle(); cycle(); cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
